// File: rtl/mpdv_pkg.sv
// Shared constants, op encodings and FSM states for the
// ones' complement multiply/divide sequencer.
package mpdv_pkg;
  localparam int WORD_W = 15;
  localparam int MAG_W = WORD_W - 1;
  localparam int ITER = MAG_W;

  localparam logic OP_MP = 1'b0;
  localparam logic OP_DV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;
endpackage

// File: rtl/mpdv_sequencer_if.sv
// Request/result bundle between a client and the
// multiply/divide sequencer.
interface mpdv_sequencer_if #(
  parameter int W = mpdv_pkg::WORD_W
);
  logic         start;
  logic         op;
  logic [W-1:0] a_in;
  logic [W-1:0] l_in;
  logic [W-1:0] x_in;
  logic         busy;
  logic         done;
  logic [W-1:0] a_out;
  logic [W-1:0] l_out;
  logic         dv_err;

  modport master (
    output start, op, a_in, l_in, x_in,
    input  busy, done, a_out, l_out, dv_err
  );

  modport slave (
    input  start, op, a_in, l_in, x_in,
    output busy, done, a_out, l_out, dv_err
  );
endinterface

// File: rtl/ones_comp_conv.sv
// Ones' complement word <-> {sign, magnitude}; the mapping is
// its own inverse, so one block serves both directions.
module ones_comp_conv
  import mpdv_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic [W-1:0] i_word,
  output logic [W-1:0] o_word
);
  assign o_word = {i_word[W-1],
                   i_word[W-2:0] ^ {(W-1){i_word[W-1]}}};
endmodule

// File: rtl/mpdv_sequencer.sv
// Iterative ones' complement multiply (shift-add) and
// divide (restoring) on one shift register and adder.
module mpdv_sequencer #(
  parameter int WORD_W = mpdv_pkg::WORD_W,
  parameter int ITER = mpdv_pkg::ITER
) (
  input logic             clk,
  input logic             rst,
  mpdv_sequencer_if.slave bus
);
  import mpdv_pkg::*;

  localparam int MW = WORD_W - 1;
  localparam int SW = 2 * MW;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  state_t            r_state;
  logic              r_op;
  logic              r_sa;
  logic              r_sx;
  logic              r_err;
  logic              r_done;
  logic              r_dv_err;
  logic [CW-1:0]     r_cnt;
  logic [MW-1:0]     r_mop;
  logic [SW-1:0]     r_sr;
  logic [WORD_W-1:0] r_a_out;
  logic [WORD_W-1:0] r_l_out;

  logic [WORD_W-1:0] w_a_sm;
  logic [WORD_W-1:0] w_x_sm;
  logic [WORD_W-1:0] w_qa_sm;
  logic [WORD_W-1:0] w_ql_sm;
  logic [WORD_W-1:0] w_a_res;
  logic [WORD_W-1:0] w_l_res;
  logic [WORD_W-1:0] w_opa;
  logic [WORD_W-1:0] w_opb;
  logic [WORD_W:0]   w_sum;
  logic [SW-1:0]     w_sr_nxt;
  logic              w_dv_bad;
  logic              w_unused;

  ones_comp_conv #(.W(WORD_W)) u_cv_a (
    .i_word(bus.a_in),
    .o_word(w_a_sm)
  );

  ones_comp_conv #(.W(WORD_W)) u_cv_x (
    .i_word(bus.x_in),
    .o_word(w_x_sm)
  );

  ones_comp_conv #(.W(WORD_W)) u_cv_qa (
    .i_word(w_qa_sm),
    .o_word(w_a_res)
  );

  ones_comp_conv #(.W(WORD_W)) u_cv_ql (
    .i_word(w_ql_sm),
    .o_word(w_l_res)
  );

  assign w_unused = bus.l_in[MW];

  assign w_dv_bad = (w_x_sm[MW-1:0] == '0) ||
                    (w_a_sm[MW-1:0] >= w_x_sm[MW-1:0]);

  // DV subtracts via ~b + 1; carry out means no borrow
  always_comb begin
    w_opa = (r_op == OP_DV) ? r_sr[SW-1:MW-1]
                            : {1'b0, r_sr[SW-1:MW]};
    w_opb = (r_op == OP_DV) ? ~{1'b0, r_mop}
                            : {1'b0, r_mop};
    w_sum = {1'b0, w_opa} + {1'b0, w_opb} +
            {{WORD_W{1'b0}}, r_op};
    if (r_op == OP_DV) begin
      if (w_sum[WORD_W])
        w_sr_nxt = {w_sum[MW-1:0], r_sr[MW-2:0], 1'b1};
      else
        w_sr_nxt = {w_opa[MW-1:0], r_sr[MW-2:0], 1'b0};
    end else begin
      if (r_sr[0])
        w_sr_nxt = {w_sum[MW:0], r_sr[MW-1:1]};
      else
        w_sr_nxt = {1'b0, r_sr[SW-1:1]};
    end
  end

  always_comb begin
    if (r_op == OP_DV) begin
      w_qa_sm = {r_sa ^ r_sx, r_sr[MW-1:0]};
      w_ql_sm = {r_sa, r_sr[SW-1:MW]};
    end else begin
      w_qa_sm = {r_sa ^ r_sx, r_sr[SW-1:MW]};
      w_ql_sm = {r_sa ^ r_sx, r_sr[MW-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MP;
      r_sa     <= 1'b0;
      r_sx     <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_dv_err <= 1'b0;
      r_cnt    <= '0;
      r_mop    <= '0;
      r_sr     <= '0;
      r_a_out  <= '0;
      r_l_out  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // the done cycle is still IDLE; refuse a start there
          if (bus.start && !r_done) begin
            r_op  <= bus.op;
            r_sa  <= w_a_sm[MW];
            r_sx  <= w_x_sm[MW];
            r_cnt <= '0;
            if (bus.op == OP_DV) begin
              r_mop   <= w_x_sm[MW-1:0];
              r_sr    <= {w_a_sm[MW-1:0], bus.l_in[MW-1:0]};
              r_err   <= w_dv_bad;
              r_state <= w_dv_bad ? S_FIN : S_RUN;
            end else begin
              r_mop   <= w_a_sm[MW-1:0];
              r_sr    <= {{MW{1'b0}}, w_x_sm[MW-1:0]};
              r_err   <= 1'b0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_sr <= w_sr_nxt;
          if (r_cnt == CW'(ITER - 1)) begin
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIN: begin
          r_done   <= 1'b1;
          r_dv_err <= r_err;
          r_a_out  <= r_err ? '0 : w_a_res;
          r_l_out  <= r_err ? '0 : w_l_res;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = r_done;
  assign bus.a_out  = r_a_out;
  assign bus.l_out  = r_l_out;
  assign bus.dv_err = r_dv_err;
endmodule

// File: tb/tb_mpdv_sequencer.sv
// Directed checks of multiply, divide, error exits,
// start filtering and reset abort on mpdv_sequencer.
module tb_mpdv_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   passed;
  int   lat;
  logic seen_done;

  mpdv_sequencer_if bus ();

  mpdv_sequencer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  // drive one request, then count edges after the
  // accepting edge until done is seen (bounded)
  task automatic run_op(input logic o,
                        input logic [14:0] a,
                        input logic [14:0] l,
                        input logic [14:0] x,
                        output int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a_in  = a;
    bus.l_in  = l;
    bus.x_in  = x;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    seen_done = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a_in  = '0;
    bus.l_in  = '0;
    bus.x_in  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_a", 32'(bus.a_out), 32'h0);
    chk("rst_l", 32'(bus.l_out), 32'h0);
    chk("rst_err", 32'(bus.dv_err), 32'd0);
    rst = 1'b0;

    run_op(1'b0, 15'd3, 15'd0, 15'd5, lat);
    chk("mp1_lat", 32'(lat), 32'd15);
    chk("mp1_a", 32'(bus.a_out), 32'h0000);
    chk("mp1_l", 32'(bus.l_out), 32'h000F);
    chk("mp1_err", 32'(bus.dv_err), 32'd0);
    @(negedge clk);
    chk("mp1_pulse", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    chk("mp1_hold", 32'(bus.l_out), 32'h000F);

    run_op(1'b0, 15'h7FFC, 15'd0, 15'd5, lat);
    chk("mp2_a", 32'(bus.a_out), 32'h7FFF);
    chk("mp2_l", 32'(bus.l_out), 32'h7FF0);

    run_op(1'b0, 15'h3FFF, 15'd0, 15'h3FFF, lat);
    chk("mp3_a", 32'(bus.a_out), 32'h3FFE);
    chk("mp3_l", 32'(bus.l_out), 32'h0001);
    chk("mp3_err", 32'(bus.dv_err), 32'd0);

    run_op(1'b1, 15'd0, 15'd100, 15'd7, lat);
    chk("dv1_lat", 32'(lat), 32'd15);
    chk("dv1_q", 32'(bus.a_out), 32'd14);
    chk("dv1_r", 32'(bus.l_out), 32'd2);
    chk("dv1_err", 32'(bus.dv_err), 32'd0);

    run_op(1'b1, 15'd0, 15'd100, 15'h7FF8, lat);
    chk("dv2_q", 32'(bus.a_out), 32'h7FF1);
    chk("dv2_r", 32'(bus.l_out), 32'h0002);

    run_op(1'b1, 15'h7FFF, 15'd100, 15'd7, lat);
    chk("dv3_q", 32'(bus.a_out), 32'h7FF1);
    chk("dv3_r", 32'(bus.l_out), 32'h7FFD);

    run_op(1'b1, 15'd5, 15'd0, 15'd3, lat);
    chk("dve1_lat", 32'(lat), 32'd1);
    chk("dve1_err", 32'(bus.dv_err), 32'd1);
    chk("dve1_a", 32'(bus.a_out), 32'h0);
    chk("dve1_l", 32'(bus.l_out), 32'h0);

    run_op(1'b1, 15'd0, 15'd9, 15'h7FFF, lat);
    chk("dve2_lat", 32'(lat), 32'd1);
    chk("dve2_err", 32'(bus.dv_err), 32'd1);

    // stray start while counter is 5
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a_in  = 15'd3;
    bus.x_in  = 15'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a_in  = 15'h0100;
    bus.x_in  = 15'h0100;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 6;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_lat", 32'(lat), 32'd15);
    chk("busy_a", 32'(bus.a_out), 32'h0000);
    chk("busy_l", 32'(bus.l_out), 32'h000F);
    chk("busy_err", 32'(bus.dv_err), 32'd0);

    // reset while counter is 7
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a_in  = 15'd3;
    bus.x_in  = 15'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_a", 32'(bus.a_out), 32'h0);
    chk("abort_l", 32'(bus.l_out), 32'h0);
    chk("abort_err", 32'(bus.dv_err), 32'd0);
    repeat (20) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    chk("abort_nodone", 32'(seen_done), 32'd0);

    run_op(1'b1, 15'd0, 15'd100, 15'd7, lat);
    chk("post_lat", 32'(lat), 32'd15);
    chk("post_q", 32'(bus.a_out), 32'd14);
    chk("post_r", 32'(bus.l_out), 32'd2);

    // start raised while done is high
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_start_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("done_start_idle", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mpdv_sequencer.md
MPDV_SEQUENCER -- requirements
Module: mpdv_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 op  in  1  operation select: 0 = MP (multiply), 1 = DV (divide).
REQ-006 a_in  in  15  A operand, ones' complement, bit 14 = sign. Used as the multiplicand for MP and as the dividend upper word for DV.
REQ-007 l_in  in  15  L operand; bits 13:0 are the dividend lower magnitude for DV; ignored for MP.
REQ-008 x_in  in  15  multiplier for MP, divisor for DV; ones' complement.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 done  out  1  one-cycle pulse; a_out, l_out and dv_err are valid while done is high.
REQ-011 a_out  out  15  MP: upper product word; DV: quotient.
REQ-012 l_out  out  15  MP: lower product word; DV: remainder.
REQ-013 dv_err  out  1  DV overflow or divide-by-zero flag; valid with done.
REQ-014 Parameter WORD_W, default 15, is the word width including the sign bit.
REQ-015 Parameter ITER, default 14, is the number of iteration cycles (WORD_W-1).

Function
REQ-016 Operand conversion: magnitude = sign ? ~bits[13:0] : bits[13:0]; -0 (0x7FFF) converts to magnitude 0.
REQ-017 Output conversion: sign set -> word = {1, ~mag[13:0]}; sign clear -> {0, mag}; a negative zero result SHALL be emitted as 0x7FFF.
REQ-018 States: IDLE, RUN, FIN.
- IDLE -> RUN on start.
- RUN -> FIN after ITER iterations.
- FIN -> IDLE unconditionally.
REQ-019 When start is sampled at edge k in IDLE, the block SHALL latch the operand magnitudes, the signs and op, clear the iteration counter to 0, and enter RUN.
REQ-020 Edges k+1..k+ITER SHALL each perform exactly one iteration; the counter SHALL increment from 0 to ITER-1, and RUN -> FIN occurs at the edge where the counter equals ITER-1.
REQ-021 At edge k+ITER+1 (FIN), the block SHALL register a_out, l_out and dv_err and drive done=1 for exactly that one cycle, then return to IDLE.
REQ-022 MP iteration: shift-add over the 14-bit magnitudes into a 28-bit accumulator.
- a_out magnitude = product[27:14]; l_out magnitude = product[13:0].
- Both words carry the sign sa^sx.
REQ-023 DV iteration: restoring shift-subtract of the 28-bit dividend {|A|,|L|} by |X|.
- Quotient sign = sa^sx; remainder sign = sa.
REQ-024 DV error: if |X| = 0 or |A| >= |X| at edge k, the block SHALL skip RUN and go directly to FIN.
- done is high after edge k+1.
- dv_err=1; a_out=0 and l_out=0.
REQ-025 dv_err SHALL be 0 on every MP result and on every non-error DV result.
REQ-026 start asserted while busy SHALL be ignored, with no queuing and no effect on the current operation.
REQ-027 start asserted in the same cycle that done is high (state FIN) SHALL be ignored; a new start is accepted only in IDLE.
REQ-028 a_out, l_out and dv_err SHALL hold their last values until the next FIN.

Reset
REQ-029 rst=1 at any edge SHALL force IDLE, counter=0, busy=0, done=0, dv_err=0, a_out=0 and l_out=0.
REQ-030 Reset during RUN or FIN SHALL abort the operation without producing a done pulse.
REQ-031 rst has priority over start when both are asserted in the same cycle.

Structure
REQ-032 Shared package mpdv_pkg SHALL hold WORD_W, MAG_W (14), ITER, the op encodings (OP_MP=0, OP_DV=1) and the state enum.
REQ-033 A sub-module ones_comp_conv SHALL perform the combinational word<->sign/magnitude conversion and SHALL be instantiated for the inputs and the outputs.
REQ-034 The datapath SHALL use one shared 28-bit shift register and one 15-bit adder/subtractor for both MP and DV.

Verification
REQ-035 MP basic: a_in=3, x_in=5 -> done after edge k+15; a_out=0x0000, l_out=0x000F, dv_err=0.
REQ-036 MP negative and maximum magnitude:
- a_in=0x7FFC (-3), x_in=5 -> a_out=0x7FFF, l_out=0x7FF0.
- a_in=0x3FFF, x_in=0x3FFF -> a_out=0x3FFE, l_out=0x0001.
REQ-037 DV basic: a_in=0, l_in=100, x_in=7 -> a_out=14, l_out=2, dv_err=0, done after edge k+15.
REQ-038 DV error:
- a_in=5, l_in=0, x_in=3 -> done after edge k+1, dv_err=1, a_out=0, l_out=0.
- x_in=0x7FFF (-0) -> dv_err=1.
REQ-039 Control events:
- start pulsed at RUN counter=5 -> no effect; result and timing unchanged.
- rst at counter=7 -> busy=0 next cycle, no done, outputs 0.
- A new start after reset -> correct result.
